// File: rtl/rv32_decode_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU_Operation / ASrc codes,
// the control bundle carried through the issue buffer, and immediate extractors.
package rv32_decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_R      = 3'b000,
        ALU_I      = 3'b001,
        ALU_BRANCH = 3'b010,
        ALU_JUMP   = 3'b011,
        ALU_LOAD   = 3'b100,
        ALU_STORE  = 3'b101,
        ALU_LUI    = 3'b110,
        ALU_AUIPC  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ASRC_RS1 = 2'b00,
        ASRC_PC  = 2'b01,
        ASRC_PC4 = 2'b10
    } asrc_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        asrc_e       asrc;
        logic        bsrc;
        logic        branch_op;
        logic [31:0] extend;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } ctrl_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch-side and execute-side handshake plus the decoded bundle of decode_issue.
// master = the fetch/execute environment, slave = the decoder.
interface decode_issue_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   instruction;
    logic [ADDRESS_BITS-1:0] in_PC;

    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] PC;
    logic [2:0]              ALU_Operation;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [1:0]              ALU_ASrc;
    logic                    ALU_BSrc;
    logic                    branch_op;
    logic [DATA_WIDTH-1:0]   extend;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    illegal;

    modport master (
        output in_valid, instruction, in_PC, out_ready,
        input  in_ready, out_valid, PC, ALU_Operation, funct3, funct7, ALU_ASrc,
               ALU_BSrc, branch_op, extend, rs1, rs2, rd, illegal
    );

    modport slave (
        input  in_valid, instruction, in_PC, out_ready,
        output in_ready, out_valid, PC, ALU_Operation, funct3, funct7, ALU_ASrc,
               ALU_BSrc, branch_op, extend, rs1, rs2, rd, illegal
    );
endinterface

// File: rtl/decode_fields.sv
// Combinational RV32I decode: raw instruction in, execute control bundle out.
// Define DECODE_ILLEGAL_CHECK_EN to flag non-RV32I opcodes with illegal=1.
module decode_fields
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    assign opcode = instruction[6:0];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves ctrl unassigned (no latch).
        ctrl        = '0;
        ctrl.alu_op = ALU_R;
        ctrl.funct3 = instruction[14:12];
        ctrl.funct7 = instruction[31:25];
        ctrl.rs1    = instruction[19:15];
        ctrl.rs2    = instruction[24:20];
        ctrl.rd     = instruction[11:7];

        case (opcode)
            OP_R: ;
            OP_IMM: begin
                ctrl.alu_op = ALU_I;
                ctrl.bsrc   = 1'b1;
                ctrl.extend = imm_i(instruction);
            end
            OP_LOAD: begin
                ctrl.alu_op = ALU_LOAD;
                ctrl.bsrc   = 1'b1;
                ctrl.extend = imm_i(instruction);
            end
            OP_STORE: begin
                ctrl.alu_op = ALU_STORE;
                ctrl.bsrc   = 1'b1;
                ctrl.extend = imm_s(instruction);
                ctrl.rd     = 5'd0;
            end
            OP_BRANCH: begin
                ctrl.alu_op    = ALU_BRANCH;
                ctrl.branch_op = 1'b1;
                ctrl.extend    = imm_b(instruction);
                ctrl.rd        = 5'd0;
            end
            OP_JAL: begin
                ctrl.alu_op = ALU_JUMP;
                ctrl.asrc   = ASRC_PC4;
                ctrl.extend = imm_j(instruction);
                ctrl.rs1    = 5'd0;
            end
            OP_JALR: begin
                ctrl.alu_op = ALU_JUMP;
                ctrl.asrc   = ASRC_PC4;
                ctrl.extend = imm_i(instruction);
            end
            OP_LUI: begin
                ctrl.alu_op = ALU_LUI;
                ctrl.bsrc   = 1'b1;
                ctrl.extend = imm_u(instruction);
                ctrl.rs1    = 5'd0;
            end
            OP_AUIPC: begin
                ctrl.alu_op = ALU_AUIPC;
                ctrl.asrc   = ASRC_PC;
                ctrl.bsrc   = 1'b1;
                ctrl.extend = imm_u(instruction);
            end
            default: begin
                // Unknown opcodes (including instruction[1:0] != 2'b11) become ADDI x0,x0,0.
                ctrl        = '0;
                ctrl.alu_op = ALU_I;
`ifdef DECODE_ILLEGAL_CHECK_EN
                ctrl.illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// RV32I decoder with a 2-entry skid buffer between fetch and execute.
// Define DECODE_ILLEGAL_CHECK_EN to enable the illegal-opcode flag in decode_fields.
module decode_issue
    import rv32_decode_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    input  logic           report,
    decode_issue_if.slave  bus
);

    ctrl_t dec_ctrl;

    decode_fields u_fields (
        .instruction (bus.instruction[31:0]),
        .ctrl        (dec_ctrl)
    );

    ctrl_t                   main_q, main_d, skid_q, skid_d;
    logic [ADDRESS_BITS-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic                    main_valid_q, main_valid_d;
    logic                    skid_valid_q, skid_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    accept, main_free;

    always_comb begin
        accept       = bus.in_valid & in_ready_q & ~flush;
        main_free    = ~main_valid_q | bus.out_ready;
        main_d       = main_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            // in_ready is low whenever skid is full, so skid refill and accept never coincide.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_pc_d    = skid_pc_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_ctrl;
                main_pc_d    = bus.in_PC;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_ctrl;
            skid_pc_d    = bus.in_PC;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    // NOTE: payload registers are reset too, so every output reads 0 the moment reset asserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking updates keep all flops sampling pre-edge values.
            main_q       <= main_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = main_valid_q;
    assign bus.PC            = main_pc_q;
    assign bus.ALU_Operation = main_q.alu_op;
    assign bus.funct3        = main_q.funct3;
    assign bus.funct7        = main_q.funct7;
    assign bus.ALU_ASrc      = main_q.asrc;
    assign bus.ALU_BSrc      = main_q.bsrc;
    assign bus.branch_op     = main_q.branch_op;
    assign bus.extend        = DATA_WIDTH'(main_q.extend);
    assign bus.rs1           = main_q.rs1;
    assign bus.rs2           = main_q.rs2;
    assign bus.rd            = main_q.rd;
    assign bus.illegal       = main_q.illegal;

    // Bundle reporting is a simulation-only concern; these inputs have no hardware effect.
    logic unused_inputs;
    assign unused_inputs = ^{report, CORE[0]};

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed decode vectors, back-pressure,
// flush, asynchronous reset and a randomized run against a depth-2 FIFO model.
module tb_decode_issue;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  asrc;
        logic        bsrc;
        logic        br;
        logic [31:0] ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
        logic [19:0] pc;
    } exp_t;

    logic clock;
    logic reset;
    logic flush;
    logic report;

    int   checks;
    int   errors;
    exp_t mq[$];
    exp_t shown;

    decode_issue_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus ();

    decode_issue #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .report (report),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Expected bundle computed with plain arithmetic on the instruction word.
    function automatic exp_t model(input logic [31:0] ins, input logic [19:0] pc);
        exp_t               e;
        logic signed [31:0] s;
        logic [31:0]        i_imm, s_imm, b_imm, j_imm, u_imm;
        s     = $signed(ins);
        i_imm = 32'(s >>> 20);
        s_imm = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
        b_imm = (32'(s >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
              | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        j_imm = (32'(s >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
              | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        e     = '0;
        e.pc  = pc;
        e.f3  = ins[14:12];
        e.f7  = ins[31:25];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: e.op = 3'd0;
            7'h13: begin e.op = 3'd1; e.bsrc = 1'b1; e.ext = i_imm; end
            7'h03: begin e.op = 3'd4; e.bsrc = 1'b1; e.ext = i_imm; end
            7'h23: begin e.op = 3'd5; e.bsrc = 1'b1; e.ext = s_imm; e.rd = 5'd0; end
            7'h63: begin e.op = 3'd2; e.br = 1'b1; e.ext = b_imm; e.rd = 5'd0; end
            7'h6F: begin e.op = 3'd3; e.asrc = 2'b10; e.ext = j_imm; e.rs1 = 5'd0; end
            7'h67: begin e.op = 3'd3; e.asrc = 2'b10; e.ext = i_imm; end
            7'h37: begin e.op = 3'd6; e.bsrc = 1'b1; e.ext = u_imm; e.rs1 = 5'd0; end
            7'h17: begin e.op = 3'd7; e.asrc = 2'b01; e.bsrc = 1'b1; e.ext = u_imm; end
            default: begin
                e    = '0;
                e.pc = pc;
                e.op = 3'd1;
`ifdef DECODE_ILLEGAL_CHECK_EN
                e.ill = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.op   = bus.ALU_Operation;
        o.f3   = bus.funct3;
        o.f7   = bus.funct7;
        o.asrc = bus.ALU_ASrc;
        o.bsrc = bus.ALU_BSrc;
        o.br   = bus.branch_op;
        o.ext  = bus.extend;
        o.rs1  = bus.rs1;
        o.rs2  = bus.rs2;
        o.rd   = bus.rd;
        o.ill  = bus.illegal;
        o.pc   = bus.PC;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r   = $urandom();
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 8)]};
    endfunction

    // Called at a falling edge: drives one cycle of inputs, steps the model at the
    // rising edge and returns at the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [19:0] pc,
                         input logic ordy, input logic fl);
        bit acc, drn;
        bus.in_valid    = v;
        bus.instruction = ins;
        bus.in_PC       = pc;
        bus.out_ready   = ordy;
        flush           = fl;
        acc = v && (mq.size() < 2) && !fl;
        drn = (mq.size() > 0) && ordy && !fl;
        @(posedge clock);
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(model(ins, pc));
        end
        if (mq.size() > 0) shown = mq[0];
        @(negedge clock);
    endtask

    task automatic test_reset();
        exp_t o;
        o = observed();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (o !== exp_t'('0)) begin
            errors++; $display("FAIL reset_bundle got %h want 0", o);
        end
    endtask

    task automatic test_decode_vectors();
        exp_t        o;
        logic [63:0] got, want;

        cycle(1'b1, 32'h002081B3, 20'h00100, 1'b1, 1'b0);
        o = observed();
        got  = 64'({bus.out_valid, o.op, o.f3, o.f7, o.rs1, o.rs2, o.rd, o.asrc, o.bsrc, o.pc});
        want = 64'({1'b1, 3'b000, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 20'h00100});
        checks++;
        if (got !== want) begin errors++; $display("FAIL add_decode got %h want %h", got, want); end

        cycle(1'b1, 32'h40335293, 20'h00104, 1'b1, 1'b0);
        o = observed();
        got  = 64'({bus.out_valid, o.op, o.f3, o.f7, o.ext, o.bsrc, o.rd});
        want = 64'({1'b1, 3'b001, 3'b101, 7'b0100000, 32'h00000403, 1'b1, 5'd5});
        checks++;
        if (got !== want) begin errors++; $display("FAIL srai_decode got %h want %h", got, want); end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL streaming_in_ready got %b want 1", bus.in_ready);
        end

        cycle(1'b1, 32'hFE208EE3, 20'h00108, 1'b1, 1'b0);
        o = observed();
        got  = 64'({bus.out_valid, o.op, o.br, o.ext, o.rd});
        want = 64'({1'b1, 3'b010, 1'b1, 32'hFFFFFFFC, 5'd0});
        checks++;
        if (got !== want) begin errors++; $display("FAIL beq_decode got %h want %h", got, want); end

        cycle(1'b1, 32'h008000EF, 20'h0010C, 1'b1, 1'b0);
        o = observed();
        got  = 64'({bus.out_valid, o.op, o.asrc, o.ext, o.rs1, o.rd});
        want = 64'({1'b1, 3'b011, 2'b10, 32'h00000008, 5'd0, 5'd1});
        checks++;
        if (got !== want) begin errors++; $display("FAIL jal_decode got %h want %h", got, want); end

        cycle(1'b1, 32'h123452B7, 20'h00110, 1'b1, 1'b0);
        o = observed();
        got  = 64'({bus.out_valid, o.op, o.ext, o.rs1, o.bsrc});
        want = 64'({1'b1, 3'b110, 32'h12345000, 5'd0, 1'b1});
        checks++;
        if (got !== want) begin errors++; $display("FAIL lui_decode got %h want %h", got, want); end

        cycle(1'b1, 32'hFFFFFFFF, 20'h00114, 1'b1, 1'b0);
        o = observed();
`ifdef DECODE_ILLEGAL_CHECK_EN
        got  = 64'({bus.out_valid, o.ill, o.rd, o.br});
        want = 64'({1'b1, 1'b1, 5'd0, 1'b0});
`else
        got  = 64'({bus.out_valid, o.op, o.f3, o.f7, o.asrc, o.bsrc, o.br, o.ext, o.rs1, o.rs2, o.rd, o.ill});
        want = 64'({1'b1, 3'b001, 3'b0, 7'b0, 2'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0});
`endif
        checks++;
        if (got !== want) begin errors++; $display("FAIL unknown_decode got %h want %h", got, want); end

        cycle(1'b0, 32'h0, 20'h0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [19:0] pcs [3];
        pcs = '{20'hA0000, 20'hB0000, 20'hC0000};
        cycle(1'b1, 32'h00100093, pcs[0], 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, pcs[1], 1'b0, 1'b0);
        cycle(1'b1, 32'h00300193, pcs[2], 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_in_ready got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.PC !== pcs[0]) begin
            errors++; $display("FAIL bp_hold_head got %b/%h want 1/%h", bus.out_valid, bus.PC, pcs[0]);
        end
        // Release: A, B, C must appear on consecutive cycles with C held at the input.
        for (int k = 1; k < 3; k++) begin
            cycle(1'b1, 32'h00300193, pcs[2], 1'b1, 1'b0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.PC !== pcs[k]) begin
                errors++; $display("FAIL bp_issue_%0d got %b/%h want 1/%h", k, bus.out_valid, bus.PC, pcs[k]);
            end
        end
        cycle(1'b0, 32'h0, 20'h0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_duplicate got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'h00100093, 20'h01000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 20'h01004, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_setup got %b/%b want 0/1", bus.in_ready, bus.out_valid);
        end
        cycle(1'b1, 32'h00300193, 20'h01008, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_clear got %b/%b want 0/1", bus.out_valid, bus.in_ready);
        end
        cycle(1'b0, 32'h0, 20'h0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop_input got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        exp_t o;
        cycle(1'b1, 32'h40335293, 20'h02000, 1'b0, 1'b0);
        cycle(1'b1, 32'h123452B7, 20'h02004, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 o = observed();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_hs got %b/%b want 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (o !== exp_t'('0)) begin
            errors++; $display("FAIL async_reset_bundle got %h want 0", o);
        end
        mq.delete();
        shown = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        exp_t        o;
        logic [31:0] r;
        for (int n = 0; n < 600; n++) begin
            o = observed();
            checks++;
            if (bus.out_valid !== (mq.size() > 0)) begin
                errors++; $display("FAIL rand_out_valid cycle %0d got %b want %b", n, bus.out_valid, mq.size() > 0);
            end
            checks++;
            if (bus.in_ready !== (mq.size() < 2)) begin
                errors++; $display("FAIL rand_in_ready cycle %0d got %b want %b", n, bus.in_ready, mq.size() < 2);
            end
            checks++;
            if (o !== shown) begin
                errors++; $display("FAIL rand_bundle cycle %0d got %h want %h", n, o, shown);
            end
            r = $urandom();
            cycle($urandom_range(0, 3) != 0, rand_instr(), r[19:0],
                  $urandom_range(0, 2) != 0, $urandom_range(0, 22) == 0);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        shown           = '0;
        reset           = 1'b0;
        flush           = 1'b0;
        report          = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        bus.in_PC       = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_decode_vectors();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
